// File: rtl/spm_offset_move_sequencer_pkg.sv
// spm_ctrl_pkg: shared state type, word width and magnitude helper
// for the offset move sequencer.
package spm_ctrl_pkg;
    localparam int DATA_W = 32;
    localparam logic [DATA_W:0] MIN_W = {1'b1, {DATA_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RAMP, SETTLE, DONE} state_e;

    function automatic logic [DATA_W:0] abs_sat(input logic signed [DATA_W:0] v);
        return v[DATA_W] ? ((v == MIN_W) ? ~MIN_W : -v) : v;
    endfunction
endpackage

// File: rtl/spm_offset_move_sequencer_if.sv
// spm_offset_move_sequencer_if: two-requester move-request handshake
// carrying signed XYZ target offsets.
interface spm_offset_move_sequencer_if;
    import spm_ctrl_pkg::*;
    logic s0_valid, s0_ready, s1_valid, s1_ready;
    logic signed [DATA_W-1:0] s0_x, s0_y, s0_z, s1_x, s1_y, s1_z;

    modport master (
        output s0_valid, s0_x, s0_y, s0_z, s1_valid, s1_x, s1_y, s1_z,
        input  s0_ready, s1_ready
    );
    modport slave (
        input  s0_valid, s0_x, s0_y, s0_z, s1_valid, s1_x, s1_y, s1_z,
        output s0_ready, s1_ready
    );
endinterface

// File: rtl/spm_offset_move_sequencer_axis_ramp.sv
// spm_axis_ramp: one-axis rate-limited stepper toward a latched target.
module spm_axis_ramp
    import spm_ctrl_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic                     tick_i,
    input  logic signed [DATA_W-1:0] target_i,
    input  logic [DATA_W-2:0]        step_i,
    output logic signed [DATA_W-1:0] cur_o,
    output logic                     arrived_o
);
    logic signed [DATA_W-1:0] cur_q, cur_d, tgt_q;
    logic [DATA_W-2:0] step_q;
    logic signed [DATA_W:0] diff;
    logic [DATA_W:0] mag;

    // The distance is taken one bit wider so opposite full-scale endpoints
    // cannot wrap; a step never overshoots, so cur stays between endpoints.
    always_comb begin
        diff = {tgt_q[DATA_W-1], tgt_q} - {cur_q[DATA_W-1], cur_q};
        mag = abs_sat(diff);
        arrived_o = mag <= {2'b00, step_q};
        cur_d = arrived_o ? tgt_q : diff[DATA_W] ? cur_q - {1'b0, step_q} : cur_q + {1'b0, step_q};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q <= '0;
            tgt_q <= '0;
            step_q <= (DATA_W-1)'(1);
        end else begin
            if (load_i) begin
                tgt_q <= target_i;
                step_q <= (step_i == '0) ? (DATA_W-1)'(1) : step_i;
            end
            if (tick_i) cur_q <= cur_d;
        end
    end

    assign cur_o = cur_q;
endmodule

// File: rtl/spm_offset_move_sequencer.sv
// spm_offset_move_sequencer: arbitrates two move requesters and ramps the
// XYZ offsets toward the granted target, then settles and reports.
module spm_offset_move_sequencer
    import spm_ctrl_pkg::*;
#(
    parameter int RDECI    = 5,
    parameter int SETTLE_W = 16
) (
    input  logic                     a_clk,
    input  logic                     a_resetn,
    spm_offset_move_sequencer_if.slave req,
    input  logic [DATA_W-1:0]        xy_step_i,
    input  logic [DATA_W-1:0]        z_step_i,
    input  logic [SETTLE_W-1:0]      settle_ticks_i,
    input  logic                     abort_i,
    output logic signed [DATA_W-1:0] x0_o,
    output logic signed [DATA_W-1:0] y0_o,
    output logic signed [DATA_W-1:0] z0_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     aborted_o,
    output logic                     grant_id_o
);
    state_e state_q, state_d;
    logic [RDECI-1:0] tick_q;
    logic [SETTLE_W-1:0] settle_q, cnt_q, cnt_d;
    logic last_q, grant_q, aborted_q;
    logic win, accept, tick, step_en, kill, unused_msb;
    logic [2:0] arr;
    logic signed [DATA_W-1:0] tx, ty, tz;

    assign unused_msb = xy_step_i[DATA_W-1] ^ z_step_i[DATA_W-1];
    assign tick = tick_q == '0;
    // last_q points at the previous winner; on contention the other one wins.
    assign win = (req.s0_valid && req.s1_valid) ? !last_q : req.s1_valid;
    assign req.s0_ready = state_q == IDLE && req.s0_valid && !win;
    assign req.s1_ready = state_q == IDLE && req.s1_valid && win;
    assign accept = req.s0_ready || req.s1_ready;
    assign kill = abort_i && (state_q == RAMP || state_q == SETTLE);
    assign step_en = state_q == RAMP && tick && !abort_i;
    assign tx = win ? req.s1_x : req.s0_x;
    assign ty = win ? req.s1_y : req.s0_y;
    assign tz = win ? req.s1_z : req.s0_z;

    spm_axis_ramp u_x (.clk_i(a_clk), .rst_ni(a_resetn), .load_i(accept), .tick_i(step_en),
        .target_i(tx), .step_i(xy_step_i[DATA_W-2:0]), .cur_o(x0_o), .arrived_o(arr[0]));
    spm_axis_ramp u_y (.clk_i(a_clk), .rst_ni(a_resetn), .load_i(accept), .tick_i(step_en),
        .target_i(ty), .step_i(xy_step_i[DATA_W-2:0]), .cur_o(y0_o), .arrived_o(arr[1]));
    spm_axis_ramp u_z (.clk_i(a_clk), .rst_ni(a_resetn), .load_i(accept), .tick_i(step_en),
        .target_i(tz), .step_i(z_step_i[DATA_W-2:0]), .cur_o(z0_o), .arrived_o(arr[2]));

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: state_d = accept ? RAMP : IDLE;
            RAMP: begin
                cnt_d = '0;
                state_d = kill ? IDLE : (tick && &arr) ? SETTLE : RAMP;
            end
            SETTLE: begin
                cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
                state_d = kill ? IDLE : (settle_q == '0 || (tick && cnt_d == settle_q)) ? DONE : SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q <= IDLE;
            tick_q <= '0;
            cnt_q <= '0;
            settle_q <= '0;
            last_q <= 1'b1;
            grant_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q <= tick_q + 1'b1;
            cnt_q <= cnt_d;
            aborted_q <= kill;
            if (accept) begin
                last_q <= win;
                grant_q <= win;
                settle_q <= settle_ticks_i;
            end
        end
    end

    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
    assign aborted_o = aborted_q;
    assign grant_id_o = grant_q;
endmodule

// File: doc/spm_offset_move_sequencer.md
# spm_offset_move_sequencer

Sequences smooth absolute-offset moves (X0, Y0, Z0) for the SPM control datapath. Two requesters (host register interface and the auto-approach/tracking engine) submit target vectors over a valid/ready handshake. A round-robin arbiter grants one move at a time. The block ramps its registered offset outputs toward the target at a programmable rate-limited step, waits a settle time, then reports completion. Its outputs feed the x0/y0/z0 inputs of the scan/offset datapath.

## Interface
- DATA_W, 32, offset and step word width (signed Q31 full scale)
- RDECI, 5, tick period is 2^RDECI clocks
- SETTLE_W, 16, settle counter width

- a_clk  in  1  clock
- a_resetn  in  1  reset, asynchronous, active-low
- s0_valid / s1_valid  in  1  move request, requester 0 / 1
- s0_ready / s1_ready  out  1  request accepted when valid && ready
- s0_x, s0_y, s0_z / s1_x, s1_y, s1_z  in  DATA_W each  signed target offsets
- xy_step  in  DATA_W  max XY change per tick, unsigned, bit 31 ignored
- z_step  in  DATA_W  max Z change per tick, unsigned, bit 31 ignored
- settle_ticks  in  SETTLE_W  ticks to wait after arrival
- abort  in  1  cancel the active move
- x0, y0, z0  out  DATA_W  current offset to datapath
- busy  out  1  state not IDLE
- done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle abort pulse
- grant_id  out  1  requester of the current or last move

## Operation
- States:
  - IDLE: ready is asserted to the arbitration winner only. On accept, latch the targets, the step sizes and grant_id, then go to RAMP.
  - RAMP: on each tick, step every axis; if all three axes equal their targets after the update, go to SETTLE.
  - SETTLE: count settle_ticks ticks, then go to DONE. With settle_ticks = 0, go to DONE on the next cycle.
  - DONE: pulse done for one cycle, then go to IDLE.
- Arbitration:
  - Round-robin with a last-grant pointer. The pointer resets to favour requester 0.
  - If only one requester is valid, it wins.
  - Both ready outputs are 0 outside IDLE.
- Per-axis step rule:
  - d = target − cur, computed at DATA_W+1 bits.
  - If |d| ≤ step, cur = target; otherwise cur = cur ± step.
  - The result never exceeds the range of either endpoint, so no wrap-around is possible.
  - A step of 0 is treated as 1.
- Tick generation: a free-running RDECI-bit counter produces a tick when it equals 0. The counter runs from reset and is not restarted on accept.
- Abort:
  - In RAMP or SETTLE, abort goes to IDLE on the next cycle with the position held and aborted pulsed. done is not pulsed.
  - abort is ignored in IDLE and DONE.
- Outputs x0/y0/z0 change only in RAMP. They keep their value between moves.

## Timing
- Reset values:
  - x0 = y0 = z0 = 0
  - busy = done = aborted = 0
  - grant_id = 0
  - s0_ready = s1_ready = 0
  - state IDLE, tick counter 0, pointer favours 0
- After reset release, ready can assert combinationally in the first cycle.
- Accept in cycle N: busy = 1 from N+1, and the latched targets apply from N+1.
- The first step occurs on the first tick after N+1, within 2^RDECI cycles. x0/y0/z0 update one cycle after the tick cycle.
- If the target equals the current position at accept, SETTLE is entered after the first tick.
- done rises one cycle after the final settle tick. Ready can reassert in the cycle after done.
- Changing xy_step, z_step or settle_ticks mid-move has no effect, because they are latched at accept.
- Reset asserted mid-move: all outputs return to their reset values immediately (asynchronous). Any in-flight request is lost.

## Structure
- Package spm_ctrl_pkg holds:
  - the state enum (IDLE, RAMP, SETTLE, DONE)
  - DATA_W
  - the saturating absolute-value helper
- Sub-module spm_axis_ramp is a one-axis stepper holding cur, target and step. It has a tick input and an arrived output, and is instantiated three times.
- The FSM, arbiter and tick counter live in the top level.

## Test plan
- RDECI=2, xy_step=32, z_step=4, settle_ticks=2, requester 0 target (100,−100,10):
  - x0 steps 32, 64, 96, 100 and y0 mirrors it negatively.
  - z0 steps 4, 8, 10.
  - done fires 2 ticks after arrival, and grant_id = 0.
- Both requesters valid in the first IDLE cycle after reset:
  - requester 0 is accepted first.
  - requester 1 is accepted in the IDLE cycle after done.
  - With both valid again, requester 0 wins.
- x0 = 0x7FFFFFF0, target 0x7FFFFFFF, xy_step = 0x40000000: x0 lands exactly on 0x7FFFFFFF with no wrap. The symmetric case toward 0x80000001 behaves the same way.
- Abort asserted 2 ticks into a RAMP from 0 to 1000 with step 10:
  - x0 holds at 20 and aborted pulses once; done stays low.
  - ready asserts in the following cycle.
- xy_step = 0 with target x = 3: x0 steps 1, 2, 3. A target equal to the current position completes after settle with no output change.
- Reset asserted mid-ramp: x0/y0/z0/busy drop to 0 the same cycle. After release, a new request is accepted normally.
